// File: rtl/data_mem_unit_if.sv
// Request/response bundle between the core control path and the data memory unit.
interface data_mem_unit_if;
    logic        MemReq;
    logic        MemWrite;
    logic [2:0]  Funct3;
    logic [31:0] ALUResult;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        MemDone;
    logic        MemBusy;
    logic        MisalignErr;

    modport master (
        output MemReq, MemWrite, Funct3, ALUResult, WriteData,
        input  ReadData, MemDone, MemBusy, MisalignErr
    );
    modport slave (
        input  MemReq, MemWrite, Funct3, ALUResult, WriteData,
        output ReadData, MemDone, MemBusy, MisalignErr
    );
endinterface

// File: rtl/data_mem_unit.sv
// Multi-cycle RISC-V data memory: fixed-latency load/store with byte/half extraction.
// Optional DMEM_ALIGN_CHECK_EN rejects misaligned half/word accesses instead of truncating.
module data_mem_unit #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    data_mem_unit_if.slave   bus
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          we_q;
    logic [2:0]    f3_q;
    logic [AW+1:0] addr_q;
    logic [31:0]   wdata_q;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;
    logic          accept;

    logic [31:0]   mem [DEPTH_WORDS];

    logic [AW-1:0] idx;
    logic [1:0]    off;
    logic          f3_ok, misalign, ok, access, mem_we;
    logic [31:0]   word, ld_val, wr_word;
    logic [7:0]    bsel;
    logic [15:0]   hsel;

    always_comb begin
        idx   = addr_q[2 +: AW];
        word  = mem[idx];
        f3_ok = f3_q inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
`ifdef DMEM_ALIGN_CHECK_EN
        misalign = (f3_q[1:0] == 2'b01 && addr_q[0]) ||
                   (f3_q[1:0] == 2'b10 && addr_q[1:0] != 2'b00);
`else
        misalign = 1'b0;
`endif
        // Offset bits below the access size are dropped, so half/word never straddle lanes
        off = addr_q[1:0];
        if (f3_q[1:0] == 2'b01) off[0] = 1'b0;
        if (f3_q[1:0] == 2'b10) off    = 2'b00;

        bsel = word[{off, 3'b000} +: 8];
        hsel = word[{off[1], 4'b0000} +: 16];
        case (f3_q)
            3'b000:  ld_val = {{24{bsel[7]}}, bsel};
            3'b001:  ld_val = {{16{hsel[15]}}, hsel};
            3'b100:  ld_val = {24'b0, bsel};
            3'b101:  ld_val = {16'b0, hsel};
            default: ld_val = word;
        endcase

        wr_word = word;
        case (f3_q[1:0])
            2'b00:   wr_word[{off, 3'b000} +: 8]     = wdata_q[7:0];
            2'b01:   wr_word[{off[1], 4'b0000} +: 16] = wdata_q[15:0];
            default: wr_word = wdata_q;
        endcase
    end

    assign ok     = f3_ok && !misalign;
    assign access = (state_q == S_WAIT) && (cnt_q == '0);
    assign mem_we = access && we_q && ok;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        accept  = 1'b0;
        case (state_q)
            S_IDLE: if (bus.MemReq) begin
                accept  = 1'b1;
                cnt_d   = CW'(LATENCY - 1);
                state_d = S_WAIT;
            end
            S_WAIT: if (cnt_q == '0) begin
                state_d = S_DONE;
                err_d   = !ok;
                if (!we_q && ok) rdata_d = ld_val;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
            S_DONE: begin
                state_d = S_IDLE;
                err_d   = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (accept) begin
                we_q    <= bus.MemWrite;
                f3_q    <= bus.Funct3;
                addr_q  <= bus.ALUResult[AW+1:0];
                wdata_q <= bus.WriteData;
            end
        end
    end

    // Array is deliberately not reset; write enable is gated by the async-reset FSM
    always_ff @(posedge clk) begin
        if (mem_we) mem[idx] <= wr_word;
    end

    assign bus.ReadData    = rdata_q;
    assign bus.MemDone     = (state_q == S_DONE);
    assign bus.MemBusy     = (state_q != S_IDLE);
    assign bus.MisalignErr = err_q;
endmodule

// File: tb/tb_data_mem_unit.sv
// Directed table-driven bench for data_mem_unit plus hand-written multi-cycle sequences.
module tb_data_mem_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    data_mem_unit_if bus();
    data_mem_unit #(.DEPTH_WORDS(1024), .LATENCY(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    localparam logic [2:0] F_B = 3'b000, F_H = 3'b001, F_W = 3'b010,
                           F_BU = 3'b100, F_HU = 3'b101, F_BAD = 3'b011;

    typedef struct {
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vecs[21];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic do_req(input vec_t v, input string tag);
        int lat;
        @(negedge clk);
        bus.MemReq    = 1'b1;
        bus.MemWrite  = v.wr;
        bus.Funct3    = v.f3;
        bus.ALUResult = v.addr;
        bus.WriteData = v.wdata;
        @(posedge clk);
        #1 bus.MemReq = 1'b0;
        chk({tag, " busy_after_accept"}, 32'(bus.MemBusy), 32'd1);
        lat = 0;
        while (!bus.MemDone && lat < 20) begin
            @(posedge clk);
            #1 lat++;
        end
        chk({tag, " latency"}, 32'(lat), 32'd2);
        chk({tag, " busy_in_done"}, 32'(bus.MemBusy), 32'd1);
        chk({tag, " rdata"}, bus.ReadData, v.exp_rd);
        chk({tag, " err"}, 32'(bus.MisalignErr), 32'(v.exp_err));
        @(posedge clk);
        #1;
        chk({tag, " done_pulse_end"}, 32'(bus.MemDone), 32'd0);
        chk({tag, " idle_after"}, 32'(bus.MemBusy), 32'd0);
    endtask

    initial begin
        int lat;
        int ndone;
        vec_t v;

        vecs[0]  = '{1'b1, F_W,   32'h40,   32'hDEADBEEF, 32'h00000000, 1'b0};
        vecs[1]  = '{1'b0, F_W,   32'h40,   32'h0,        32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b1, F_W,   32'h10,   32'h80F07F81, 32'hDEADBEEF, 1'b0};
        vecs[3]  = '{1'b0, F_B,   32'h10,   32'h0,        32'hFFFFFF81, 1'b0};
        vecs[4]  = '{1'b0, F_BU,  32'h13,   32'h0,        32'h00000080, 1'b0};
        vecs[5]  = '{1'b0, F_H,   32'h12,   32'h0,        32'hFFFF80F0, 1'b0};
        vecs[6]  = '{1'b0, F_HU,  32'h10,   32'h0,        32'h00007F81, 1'b0};
        vecs[7]  = '{1'b1, F_W,   32'h10,   32'h11223344, 32'h00007F81, 1'b0};
        vecs[8]  = '{1'b1, F_B,   32'h11,   32'h000000AA, 32'h00007F81, 1'b0};
        vecs[9]  = '{1'b0, F_W,   32'h10,   32'h0,        32'h1122AA44, 1'b0};
        vecs[10] = '{1'b1, F_H,   32'h12,   32'h0000BEEF, 32'h1122AA44, 1'b0};
        vecs[11] = '{1'b0, F_W,   32'h10,   32'h0,        32'hBEEFAA44, 1'b0};
        vecs[12] = '{1'b1, F_W,   32'h1000, 32'hCAFEF00D, 32'hBEEFAA44, 1'b0};
        vecs[13] = '{1'b0, F_W,   32'h0,    32'h0,        32'hCAFEF00D, 1'b0};
        vecs[14] = '{1'b0, F_BAD, 32'h10,   32'h0,        32'hCAFEF00D, 1'b1};
        vecs[15] = '{1'b1, F_BAD, 32'h10,   32'h0,        32'hCAFEF00D, 1'b1};
        vecs[16] = '{1'b0, F_W,   32'h10,   32'h0,        32'hBEEFAA44, 1'b0};
`ifdef DMEM_ALIGN_CHECK_EN
        vecs[17] = '{1'b0, F_W,   32'h42,   32'h0,        32'hBEEFAA44, 1'b1};
        vecs[18] = '{1'b0, F_H,   32'h11,   32'h0,        32'hBEEFAA44, 1'b1};
`else
        vecs[17] = '{1'b0, F_W,   32'h42,   32'h0,        32'hDEADBEEF, 1'b0};
        vecs[18] = '{1'b0, F_H,   32'h11,   32'h0,        32'hFFFFAA44, 1'b0};
`endif
        vecs[19] = '{1'b0, F_B,   32'h12,   32'h0,        32'hFFFFFFEF, 1'b0};
        vecs[20] = '{1'b0, F_BU,  32'h11,   32'h0,        32'h000000AA, 1'b0};

        bus.MemReq = 1'b0; bus.MemWrite = 1'b0; bus.Funct3 = 3'b0;
        bus.ALUResult = '0; bus.WriteData = '0;

        // Reset state
        #12;
        chk("reset rdata", bus.ReadData, 32'h0);
        chk("reset done", 32'(bus.MemDone), 32'd0);
        chk("reset busy", 32'(bus.MemBusy), 32'd0);
        chk("reset err", 32'(bus.MisalignErr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) do_req(vecs[i], $sformatf("vec%0d", i));

        // MemReq held through WAIT: one access, store data latched at acceptance
        @(negedge clk);
        bus.MemReq = 1'b1; bus.MemWrite = 1'b1; bus.Funct3 = F_W;
        bus.ALUResult = 32'h20; bus.WriteData = 32'h0BADF00D;
        @(posedge clk);
        #1 bus.WriteData = 32'h55555555;
        lat = 0;
        ndone = 0;
        while (!bus.MemDone && lat < 20) begin
            @(posedge clk);
            #1 lat++;
        end
        if (bus.MemDone) ndone++;
        bus.MemReq = 1'b0;
        chk("hold latency", 32'(lat), 32'd2);
        @(posedge clk);
        #1;
        if (bus.MemDone) ndone++;
        chk("hold done_count", 32'(ndone), 32'd1);
        chk("hold idle_after", 32'(bus.MemBusy), 32'd0);
        v = '{1'b0, F_W, 32'h20, 32'h0, 32'h0BADF00D, 1'b0};
        do_req(v, "hold readback");

        // Async reset in WAIT of a store: dropped write, outputs cleared at once
        @(negedge clk);
        bus.MemReq = 1'b1; bus.MemWrite = 1'b1; bus.Funct3 = F_W;
        bus.ALUResult = 32'h40; bus.WriteData = 32'h12345678;
        @(posedge clk);
        #1 bus.MemReq = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("midrst busy", 32'(bus.MemBusy), 32'd0);
        chk("midrst done", 32'(bus.MemDone), 32'd0);
        chk("midrst rdata", bus.ReadData, 32'h0);
        chk("midrst err", 32'(bus.MisalignErr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        v = '{1'b0, F_W, 32'h40, 32'h0, 32'hDEADBEEF, 1'b0};
        do_req(v, "midrst readback");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/data_mem_unit.md
Name: data_mem_unit

Overview:
- Multi-cycle data memory unit for the RISC-V core; it produces the ReadData word consumed by the write-back result mux (ResultSrc=01).
- Accepts a load/store request with the ALU-computed address and performs the access after a fixed latency.
- Load results are byte/halfword extracted and sign/zero extended per funct3.
- Signals completion to the control FSM with a one-cycle MemDone pulse.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words in the array; power of two.
- LATENCY, 2: cycles from request acceptance to MemDone; must be ≥1.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- MemReq  input  1  request strobe; sampled only in IDLE
- MemWrite  input  1  1 = store, 0 = load
- Funct3  input  3  000 lb/sb, 001 lh/sh, 010 lw/sw, 100 lbu, 101 lhu
- ALUResult  input  32  byte address
- WriteData  input  32  store data, right-aligned
- ReadData  output  32  extended load result
- MemDone  output  1  one-cycle completion pulse
- MemBusy  output  1  high while a request is outstanding
- MisalignErr  output  1  error flag, valid only with MemDone

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, ReadData=0, MemDone=0, MemBusy=0, MisalignErr=0, counter=0. The memory array is not reset.
- FSM states: IDLE, WAIT, DONE.
- IDLE→WAIT on the edge where MemReq=1.
  - That edge latches MemWrite, Funct3, ALUResult and WriteData.
  - Counter is loaded with LATENCY-1.
- WAIT: counter decrements each cycle. When the counter is 0, the access is performed and the FSM moves to DONE on the same edge.
- DONE: MemDone=1 for exactly one cycle, then return to IDLE.
- MemDone is high during the cycle beginning LATENCY edges after the acceptance edge.
- MemBusy = (state != IDLE).
- MemReq outside IDLE is ignored and not queued. The minimum request spacing is LATENCY+1 cycles.
- Word index = latched address[2 +: log2(DEPTH_WORDS)]; upper address bits are ignored, so addresses wrap modulo DEPTH_WORDS*4.
- Loads: the byte or halfword is selected by address[1:0] or address[1].
  - lb/lh sign-extend; lbu/lhu zero-extend; lw returns the full word.
  - ReadData updates on the WAIT→DONE edge and holds until the next successful load completes.
- Stores:
  - sb writes WriteData[7:0] to the selected byte lane.
  - sh writes WriteData[15:0] to the selected halfword lane.
  - sw writes the full word.
  - Other lanes are unchanged.
  - The write occurs on the WAIT→DONE edge.
  - ReadData is unchanged by stores.
- Invalid Funct3 (011, 110, 111): no memory change, ReadData unchanged, MisalignErr=1 with MemDone.
- Reset mid-operation: the FSM returns to IDLE immediately and the pending transaction is dropped with no memory write. Previously written contents are retained.

Optional Feature:
- Macro: DMEM_ALIGN_CHECK_EN.
- Defined:
  - halfword access with address[0]=1, or word access with address[1:0]!=0, is misaligned.
  - A misaligned access performs no read or write, leaves ReadData unchanged, and asserts MisalignErr=1 during the MemDone cycle.
- Undefined:
  - No alignment check; low address bits below the access size are forced to 0 (a word access uses address[1:0]=00).
  - MisalignErr is asserted only for invalid Funct3.

Test Plan:
- Reset: assert rst_n=0 asynchronously mid-cycle → all outputs 0 immediately; state IDLE.
- Word store then load, LATENCY=2:
  - sw 0xDEADBEEF to 0x40, then lw 0x40 → MemDone 2 cycles after each acceptance; ReadData=0xDEADBEEF; MemBusy high 3 cycles per request.
- Byte/half extension:
  - After word 0x80F07F81 at 0x10: lb 0x10 → 0xFFFFFF81; lbu 0x13 → 0x00000080; lh 0x12 → 0xFFFF80F0; lhu 0x10 → 0x00007F81.
- Partial store:
  - sb 0xAA to 0x11 over 0x11223344 → lw 0x10 = 0x1122AA44.
  - sh 0xBEEF to 0x12 → 0xBEEFAA44.
- Busy/wrap:
  - MemReq held high during WAIT → exactly one access.
  - sw to 0x1000 with DEPTH_WORDS=1024 aliases word 0; a read of 0x0 returns the stored data.
- Errors:
  - Funct3=011 → MisalignErr=1 with MemDone, memory unchanged.
  - With DMEM_ALIGN_CHECK_EN: lw 0x42 → MisalignErr=1, ReadData unchanged.
- Reset mid-operation: rst_n pulsed low during WAIT of a sw → location unchanged; next request accepted normally.
